sonar_array_hub: RTL

Parametrised Wishbone hub for the sonar-on-chip array: decodes the user-area slave window at 0x3xxx_xxxx, serves local status/mask/prescaler/control registers, and forwards channel accesses to up to 15 sonar channels.

Each channel has its own point-to-point bus with a bounded-wait handshake. This replaces the shared, wire-OR'ed channel bus used previously. The hub also latches channel comparator events into a maskable sticky status register and generates the PCM clock enable.

---
 rtl/sonar_pkg.sv | 27 ++
 rtl/sonar_array_hub_ce_divider.sv | 30 +++
 rtl/sonar_array_hub.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sonar_pkg.sv
// Shared constants for the sonar array hub: register map, region nibble,
// FSM state codes and the captured bus request.
package sonar_pkg;
    localparam logic [3:0] REGION = 4'h3;

    localparam logic [5:0] OFF_STATUS    = 6'h00;
    localparam logic [5:0] OFF_MASK      = 6'h04;
    localparam logic [5:0] OFF_PRESCALER = 6'h08;
    localparam logic [5:0] OFF_CTRL      = 6'h0C;

    localparam int CTRL_TOERR  = 0;
    localparam int CTRL_MCLEAR = 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOCAL   = 2'd1;
    localparam logic [1:0] S_CH_WAIT = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    typedef struct packed {
        logic        we;
        logic        wr_ok;
        logic        mapped;
        logic [3:0]  idx;
        logic [3:0]  radr;
        logic [31:0] dat;
    } req_t;
endpackage

// File: rtl/sonar_array_hub_ce_divider.sv
// Down-counting clock-enable generator: one-cycle pulse every div+1 cycles,
// silent reload on load.
module ce_divider #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] div,
    input  logic         load,
    output logic         ce
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= RST_VAL;
            ce  <= 1'b0;
        end else if (load) begin
            cnt <= div;
            ce  <= 1'b0;
        end else if (cnt == '0) begin
            cnt <= div;
            ce  <= 1'b1;
        end else begin
            cnt <= cnt - 1'b1;
            ce  <= 1'b0;
        end
    end
endmodule

// File: rtl/sonar_array_hub.sv
// Wishbone hub for the sonar array: local status/mask/prescaler/control
// registers plus point-to-point forwarding to N_CH channels with timeout.
module sonar_array_hub
    import sonar_pkg::*;
#(
    parameter int N_CH    = 15,
    parameter int DW      = 16,
    parameter int PRE_W   = 8,
    parameter int PRE_RST = 49,
    parameter int TIMEOUT = 15
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic [N_CH-1:0]    ch_valid_o,
    output logic               ch_we_o,
    output logic [3:0]         ch_adr_o,
    output logic [DW-1:0]      ch_dat_o,
    input  logic [N_CH-1:0]    ch_ack_i,
    input  logic [N_CH*DW-1:0] ch_dat_i,
    input  logic [N_CH-1:0]    cmp_i,
    output logic               irq_o,
    output logic               mclear_o,
    output logic               ce_pcm_o
);
    logic [1:0]       state;
    req_t             req;
    logic [N_CH-1:0]  status, mask, sts_clr;
    logic [PRE_W-1:0] prescaler;
    logic             toerr;
    logic [7:0]       cnt;

    logic [3:0] nib;
    logic       hit, is_ch, is_loc;
    assign nib    = wbs_adr_i[9:6];
    assign hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == REGION);
    assign is_ch  = (nib != 4'd0) && (nib <= 4'(N_CH));
    assign is_loc = (nib == 4'd0) && (wbs_adr_i[5:4] == 2'b00);

    logic [5:0]  off;
    logic        wr, ld_pre;
    logic [31:0] loc_rd;
    assign off = {req.radr, 2'b00};

    always_comb begin
        wr      = (state == S_LOCAL) && req.we && req.wr_ok && req.mapped;
        sts_clr = '0;
        ld_pre  = 1'b0;
        loc_rd  = '0;
        if (wr && off == OFF_STATUS)    sts_clr = req.dat[N_CH-1:0];
        if (wr && off == OFF_PRESCALER) ld_pre  = 1'b1;
        if (req.mapped) begin
            case (off)
                OFF_STATUS:    loc_rd = 32'(status);
                OFF_MASK:      loc_rd = 32'(mask);
                OFF_PRESCALER: loc_rd = 32'(prescaler);
                OFF_CTRL:      loc_rd = {30'b0, mclear_o, toerr};
                default:       loc_rd = '0;
            endcase
        end
    end

    // Selected channel's read data, sign-extended to the bus width
    logic [DW-1:0] cd;
    logic [31:0]   cd_ext;
    always_comb begin
        cd     = ch_dat_i[req.idx*DW +: DW];
        cd_ext = {32{cd[DW-1]}};
        cd_ext[DW-1:0] = cd;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= S_IDLE;
            req        <= '0;
            cnt        <= '0;
            status     <= '0;
            mask       <= '0;
            prescaler  <= PRE_W'(PRE_RST);
            toerr      <= 1'b0;
            mclear_o   <= 1'b0;
            irq_o      <= 1'b0;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            ch_valid_o <= '0;
            ch_we_o    <= 1'b0;
            ch_adr_o   <= '0;
            ch_dat_o   <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
            status    <= (status & ~sts_clr) | cmp_i;
            irq_o     <= |(status & mask);
            case (state)
                S_IDLE: if (hit) begin
                    req <= '{we: wbs_we_i, wr_ok: wbs_sel_i[0], mapped: is_loc,
                             idx: nib - 4'd1, radr: wbs_adr_i[5:2], dat: wbs_dat_i};
                    cnt <= '0;
                    // A channel write without sel[0] is completed locally as a no-op
                    if (is_ch && !(wbs_we_i && !wbs_sel_i[0])) begin
                        state    <= S_CH_WAIT;
                        ch_we_o  <= wbs_we_i;
                        ch_adr_o <= wbs_adr_i[5:2];
                        ch_dat_o <= wbs_dat_i[DW-1:0];
                    end else begin
                        state <= S_LOCAL;
                    end
                end
                S_LOCAL: begin
                    wbs_dat_o <= loc_rd;
                    wbs_ack_o <= 1'b1;
                    state     <= S_RESP;
                    if (wr) begin
                        case (off)
                            OFF_MASK:      mask      <= req.dat[N_CH-1:0];
                            OFF_PRESCALER: prescaler <= req.dat[PRE_W-1:0];
                            OFF_CTRL: begin
                                if (req.dat[CTRL_TOERR]) toerr <= 1'b0;
                                mclear_o <= req.dat[CTRL_MCLEAR];
                            end
                            default: ;
                        endcase
                    end
                end
                S_CH_WAIT: begin
                    if (cnt == 8'd0) begin
                        ch_valid_o <= N_CH'(1) << req.idx;
                        cnt        <= 8'd1;
                    end else if (ch_ack_i[req.idx]) begin
                        ch_valid_o <= '0;
                        wbs_dat_o  <= cd_ext;
                        wbs_ack_o  <= 1'b1;
                        state      <= S_RESP;
                    end else if (cnt == 8'(TIMEOUT)) begin
                        ch_valid_o <= '0;
                        wbs_dat_o  <= '0;
                        wbs_ack_o  <= 1'b1;
                        toerr      <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    ce_divider #(.W(PRE_W), .RST_VAL(PRE_W'(PRE_RST))) u_ce (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .div  (ld_pre ? req.dat[PRE_W-1:0] : prescaler),
        .load (ld_pre),
        .ce   (ce_pcm_o)
    );

    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[27:10], wbs_adr_i[1:0], req.dat};
endmodule
